// File: rtl/eth_rx_frame.sv
// eth_rx_frame: GMII receive framer with preamble/SFD strip, DA filter, FCS check and status.
// Ports:
//   gmii_rx_clk    byte clock, all logic on rising edge
//   rst_n          asynchronous active-low reset
//   gmii_rx_dv     receive data valid
//   gmii_rxd       receive byte
//   m_data         forwarded byte (DA .. last payload byte)
//   m_valid        m_data valid
//   m_sop          first byte of frame
//   m_eop          last non-FCS byte
//   m_err          frame bad (CRC or length), valid with m_eop
//   stat_valid     one-cycle pulse at frame end
//   stat_good      accepted, CRC ok, length ok
//   stat_crc_err   CRC residue mismatch
//   stat_len_err   length outside MIN_LEN..MAX_LEN
//   stat_filtered  destination MAC rejected
//   stat_len       byte count DA..FCS, saturating at 2047
module eth_rx_frame #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
    parameter bit          PROMISC   = 1'b0,
    parameter int          PRE_MIN   = 1,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sop,
    output logic        m_eop,
    output logic        m_err,
    output logic        stat_valid,
    output logic        stat_good,
    output logic        stat_crc_err,
    output logic        stat_len_err,
    output logic        stat_filtered,
    output logic [10:0] stat_len
);
    typedef enum logic [1:0] {DROP, IDLE, PRE, FRAME} state_t;

    state_t          state_q, state_d;
    logic [2:0]      pre_cnt_q, pre_cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic [10:0]     cnt_q, cnt_d;
    logic [4:0][7:0] s_q, s_d;
    logic            acc_q, acc_d;
    logic [7:0]      data_d;
    logic            valid_d, sop_d, eop_d, err_d;
    logic            sv_d, sg_d, sc_d, sl_d, sf_d;
    logic [10:0]     slen_d;
    logic            crc_bad, len_bad, da_ok, short_f, fwd;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        acc_d     = acc_q;
        data_d    = 8'h00;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        sv_d      = 1'b0;
        sg_d      = 1'b0;
        sc_d      = 1'b0;
        sl_d      = 1'b0;
        sf_d      = 1'b0;
        slen_d    = 11'd0;
        crc_bad   = crc_q != 32'hDEBB20E3;
        len_bad   = 32'(cnt_q) < MIN_LEN || 32'(cnt_q) > MAX_LEN;
        // s_q[4] holds DA byte 0 when the current byte is DA byte 5
        da_ok     = PROMISC || {s_q, gmii_rxd} == LOCAL_MAC || {s_q, gmii_rxd} == 48'hFFFF_FFFF_FFFF;
        short_f   = cnt_q < 11'd6;
        fwd       = !short_f && acc_q;
        case (state_q)
            DROP: state_d = gmii_rx_dv ? DROP : IDLE;
            IDLE: begin
                pre_cnt_d = 3'd1;
                if (gmii_rx_dv)
                    state_d = gmii_rxd == 8'h55 ? PRE : DROP;
            end
            PRE: begin
                if (!gmii_rx_dv)
                    state_d = IDLE;
                else if (gmii_rxd == 8'h55)
                    pre_cnt_d = pre_cnt_q == 3'd7 ? 3'd7 : pre_cnt_q + 3'd1;
                else if (gmii_rxd == 8'hD5 && 32'(pre_cnt_q) >= PRE_MIN) begin
                    state_d = FRAME;
                    crc_d   = 32'hFFFF_FFFF;
                    cnt_d   = 11'd0;
                    acc_d   = 1'b0;
                end else
                    state_d = DROP;
            end
            FRAME: begin
                if (gmii_rx_dv) begin
                    crc_d = crc_byte(crc_q, gmii_rxd);
                    cnt_d = cnt_q == 11'h7FF ? cnt_q : cnt_q + 11'd1;
                    s_d   = {s_q[3:0], gmii_rxd};
                    if (cnt_q == 11'd5)
                        acc_d = da_ok;
                    // byte k leaves the delay line as byte k+5 arrives
                    if (cnt_q >= 11'd5 && (cnt_q == 11'd5 ? da_ok : acc_q)) begin
                        valid_d = 1'b1;
                        data_d  = s_q[4];
                        sop_d   = cnt_q == 11'd5;
                    end
                end else begin
                    // s_q[3:0] hold the FCS; s_q[4] is the last payload byte
                    state_d = IDLE;
                    valid_d = fwd;
                    eop_d   = fwd;
                    data_d  = fwd ? s_q[4] : 8'h00;
                    err_d   = fwd && (crc_bad || len_bad);
                    sv_d    = 1'b1;
                    sc_d    = crc_bad;
                    sl_d    = len_bad || short_f;
                    sf_d    = !short_f && !acc_q;
                    sg_d    = !crc_bad && !(len_bad || short_f) && !(!short_f && !acc_q);
                    slen_d  = cnt_q;
                end
            end
            default: state_d = DROP;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DROP;
            pre_cnt_q     <= 3'd0;
            crc_q         <= 32'hFFFF_FFFF;
            cnt_q         <= 11'd0;
            s_q           <= '0;
            acc_q         <= 1'b0;
            m_data        <= 8'h00;
            m_valid       <= 1'b0;
            m_sop         <= 1'b0;
            m_eop         <= 1'b0;
            m_err         <= 1'b0;
            stat_valid    <= 1'b0;
            stat_good     <= 1'b0;
            stat_crc_err  <= 1'b0;
            stat_len_err  <= 1'b0;
            stat_filtered <= 1'b0;
            stat_len      <= 11'd0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            s_q           <= s_d;
            acc_q         <= acc_d;
            m_data        <= data_d;
            m_valid       <= valid_d;
            m_sop         <= sop_d;
            m_eop         <= eop_d;
            m_err         <= err_d;
            stat_valid    <= sv_d;
            stat_good     <= sg_d;
            stat_crc_err  <= sc_d;
            stat_len_err  <= sl_d;
            stat_filtered <= sf_d;
            stat_len      <= slen_d;
        end
    end
endmodule

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
- Consumes the single-edge GMII byte stream produced by the RGMII receive front end, clocked by its gmii_rx_clk output.
- Strips the preamble and SFD, filters on destination MAC, and checks the FCS (CRC-32).
- Forwards header and payload bytes, with FCS removed, on a valid/sop/eop stream to the MAC/ARP/UDP layers.
- Emits one status pulse per frame.

Parameters:
- LOCAL_MAC, 48'h00_11_22_33_44_55, station MAC address accepted by the filter.
- PROMISC, 0, 1 = accept every destination MAC.
- PRE_MIN, 1, minimum count of 0x55 bytes required before the SFD.
- MIN_LEN, 64, minimum frame length in bytes (DA through FCS).
- MAX_LEN, 1518, maximum frame length in bytes (DA through FCS).

Ports:
- gmii_rx_clk  input  1  receive byte clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gmii_rx_dv  input  1  GMII receive data valid.
- gmii_rxd  input  8  GMII receive byte.
- m_data  output  8  forwarded frame byte (DA through last payload byte).
- m_valid  output  1  m_data valid.
- m_sop  output  1  first byte of frame; qualified by m_valid.
- m_eop  output  1  last non-FCS byte; qualified by m_valid.
- m_err  output  1  frame bad (CRC or length); valid only with m_eop.
- stat_valid  output  1  one-cycle pulse at frame end.
- stat_good  output  1  accepted, CRC ok, length ok.
- stat_crc_err  output  1  CRC residue mismatch.
- stat_len_err  output  1  length < MIN_LEN or > MAX_LEN.
- stat_filtered  output  1  destination MAC rejected; no bytes forwarded.
- stat_len  output  11  byte count DA..FCS, saturating at 2047.

Behaviour:
- Reset: all outputs 0, CRC register 32'hFFFFFFFF, counters 0, state = DROP.
- Reset is asynchronous. Reset mid-frame abandons the frame: no eop and no stat pulse are emitted.
- No backpressure. Output is registered.
- States and transitions:
  - DROP: wait until gmii_rx_dv = 0, then go to IDLE.
  - IDLE: on dv = 1 with rxd = 0x55, go to PREAMBLE with pre_cnt = 1. On dv = 1 with any other byte, go to DROP.
  - PREAMBLE, with dv = 1:
    - rxd = 0x55: pre_cnt++ (saturate at 7).
    - rxd = 0xD5 with pre_cnt >= PRE_MIN: go to FRAME and clear the CRC to FFFFFFFF.
    - Any other byte: go to DROP.
  - PREAMBLE, dv = 0: go to IDLE with no status.
  - FRAME, each dv = 1 byte: update the CRC, increment byte_cnt (saturating), and shift the byte into a 5-deep delay line s0..s4.
  - FRAME, first cycle with dv = 0: END handling (below), then IDLE.
- CRC: reflected CRC-32, poly 0x04C11DB7, bit0 of each byte first, init FFFFFFFF. Computed over DA through FCS. Good iff the register equals 32'hDEBB20E3 at END; no final XOR.
- Filter:
  - Decision registered on acceptance of byte index 5.
  - Accept if DA == LOCAL_MAC, DA == FF:FF:FF:FF:FF:FF, or PROMISC = 1.
  - Rejected frame: no m_valid for the whole frame; stat_filtered = 1 at END.
- Forwarding latency:
  - When byte k+5 is accepted and the frame is accepted, byte k appears on m_data one cycle later with m_valid = 1.
  - k = 0 carries m_sop.
- END, in the cycle after dv falls:
  - If byte_cnt >= 6 and the frame is accepted: emit s4 (last non-FCS byte) with m_valid = m_eop = 1 and m_err = crc_err | len_err. s0..s3 hold the FCS and are discarded.
  - In the same cycle pulse stat_valid with the flags and stat_len = byte_cnt.
  - byte_cnt < 6: no m_valid. Status flags are len_err = 1 plus crc_err; stat_filtered = 0.
- Flag rules:
  - stat_good = !crc_err & !len_err & !filtered.
  - Oversize frames are still forwarded in full with m_err = 1.
- Back-to-back frames: dv may rise again in the cycle after END (IFG >= 1 byte). IDLE must accept 0x55 in that cycle.

Test Plan:
- Good frame: 7×0x55, D5, 60-byte frame to LOCAL_MAC, valid FCS (64 B).
  -> 60 m_valid bytes matching input.
  -> Byte 0 is 1 cycle after DA byte 5; m_sop on byte 0.
  -> m_eop on byte 59 with m_err = 0; stat_good = 1, stat_len = 64.
- Same frame with one payload bit flipped -> m_eop with m_err = 1; stat_crc_err = 1, stat_good = 0.
- DA = 02:00:00:00:00:01, PROMISC = 0 -> m_valid never asserts; stat_filtered = 1, stat_len = 64.
  - Repeat with DA = broadcast -> forwarded, stat_good = 1.
- Runt: 40-byte frame with valid FCS -> 36 bytes forwarded, m_err = 1, stat_len_err = 1, stat_len = 40.
- Preamble 55 55 33 ... -> DROP; no m_valid and no stat until dv falls.
  - The next good frame after a 1-cycle gap is received intact.
- Assert rst_n = 0 mid-payload -> all outputs 0 immediately.
  - Release with dv still high -> rest of the frame ignored, no stat_valid.
  - Following frame good.
